// File: rtl/bus_regfile.sv
// bus_regfile: small register file sitting on a shared tri-state data bus.
//
// Each register can be loaded from the bus, driven onto it, or incremented.
// A read and a write in the same cycle copy one register into another over
// the bus. Out-of-range selects raise a sticky error flag. An 8-bit
// saturating counter tracks register-to-register transfers.
//
// Parameters
//   WIDTH : register / bus width in bits
//   DEPTH : number of registers (2..16)
//   SELW  : select width, 2**SELW >= DEPTH
// Ports
//   clk      : clock, all state updates on the rising edge
//   clr      : synchronous active-high reset
//   bus      : shared bidirectional data bus
//   wr_en    : load bus into register wr_sel
//   wr_sel   : write target
//   rd_en    : drive register rd_sel onto bus (combinational)
//   rd_sel   : read source
//   inc_en   : increment register inc_sel
//   inc_sel  : increment target
//   err_clr  : clear the sticky error flag
//   err      : sticky select-range error
//   xfer_cnt : saturating count of in-range read+write transfers
//
// Build option: define BUS_REGFILE_INC_EN to enable the increment path.
// Without it inc_en/inc_sel are ignored and never raise err.

module bus_regfile_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic             inc,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q, q_d;

  // A load beats an increment aimed at the same register.
  always_comb begin
    q_d = q_q;
    if (ld)       q_d = ld_val;
    else if (inc) q_d = q_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

module bus_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SELW  = 2
) (
  input  logic            clk,
  input  logic            clr,
  inout  wire [WIDTH-1:0] bus,
  input  logic            wr_en,
  input  logic [SELW-1:0] wr_sel,
  input  logic            rd_en,
  input  logic [SELW-1:0] rd_sel,
  input  logic            inc_en,
  input  logic [SELW-1:0] inc_sel,
  input  logic            err_clr,
  output logic            err,
  output logic [7:0]      xfer_cnt
);
  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [WIDTH-1:0]            rd_data;
  logic                        rd_ok, wr_ok, inc_ok, inc_act, err_set, xfer;
  logic                        err_q, err_d;
  logic [7:0]                  xfer_cnt_q, xfer_cnt_d;

  assign rd_ok  = int'(rd_sel)  < DEPTH;
  assign wr_ok  = int'(wr_sel)  < DEPTH;
  assign inc_ok = int'(inc_sel) < DEPTH;

`ifdef BUS_REGFILE_INC_EN
  assign inc_act = inc_en;
`else
  logic unused_inc;
  assign unused_inc = inc_en;
  assign inc_act    = 1'b0;
`endif

  // Mux by comparison so a non-power-of-two DEPTH never indexes past the array.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (int'(rd_sel) == i) rd_data = regs[i];
  end

  // clr releases the bus immediately, even mid-transfer.
  assign bus = (rd_en && rd_ok && !clr) ? rd_data : 'z;

  // Writes always take the resolved bus value, so read+write is a copy and
  // a write with the bus undriven by us latches the external driver.
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    bus_regfile_cell #(.WIDTH(WIDTH)) u_cell (
      .clk    (clk),
      .clr    (clr),
      .ld     (wr_en && (int'(wr_sel) == i)),
      .inc    (inc_act && (int'(inc_sel) == i)),
      .ld_val (bus),
      .q      (regs[i])
    );
  end

  assign err_set = (rd_en && !rd_ok) || (wr_en && !wr_ok) || (inc_act && !inc_ok);
  assign xfer    = rd_en && wr_en && rd_ok && wr_ok;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
    xfer_cnt_d = xfer_cnt_q;
    if (xfer && (xfer_cnt_q != 8'hFF)) xfer_cnt_d = xfer_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      err_q      <= 1'b0;
      xfer_cnt_q <= 8'd0;
    end else begin
      err_q      <= err_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign err      = err_q;
  assign xfer_cnt = xfer_cnt_q;
endmodule

// File: tb/tb_bus_regfile.sv
// Bench for bus_regfile: two instances (DEPTH=4 and DEPTH=3) share the same
// control inputs, each on its own bus. Stimulus pushes per-cycle expectations
// from an array-based reference model; a negedge monitor pops and compares.
// Whenever a DUT must not drive its bus the bench drives it itself, so any
// stray DUT drive corrupts the observed value.
module tb_bus_regfile;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr, rd_en, wr_en, inc_en, err_clr;
  logic [1:0] rd_sel, wr_sel, inc_sel;
  logic       drv4, drv3;
  logic [7:0] tb_val;
  wire  [7:0] bus4, bus3;
  logic       err4, err3;
  logic [7:0] cnt4, cnt3;

  assign bus4 = drv4 ? tb_val : 'z;
  assign bus3 = drv3 ? tb_val : 'z;

  bus_regfile #(.WIDTH(8), .DEPTH(4), .SELW(2)) u_dut4 (
    .clk(clk), .clr(clr), .bus(bus4), .wr_en(wr_en), .wr_sel(wr_sel),
    .rd_en(rd_en), .rd_sel(rd_sel), .inc_en(inc_en), .inc_sel(inc_sel),
    .err_clr(err_clr), .err(err4), .xfer_cnt(cnt4));

  bus_regfile #(.WIDTH(8), .DEPTH(3), .SELW(2)) u_dut3 (
    .clk(clk), .clr(clr), .bus(bus3), .wr_en(wr_en), .wr_sel(wr_sel),
    .rd_en(rd_en), .rd_sel(rd_sel), .inc_en(inc_en), .inc_sel(inc_sel),
    .err_clr(err_clr), .err(err3), .xfer_cnt(cnt3));

`ifdef BUS_REGFILE_INC_EN
  localparam bit INC_ON = 1'b1;
`else
  localparam bit INC_ON = 1'b0;
`endif

  typedef struct {
    bit         chk;
    logic [7:0] b4, b3;
    logic       e4, e3;
    logic [7:0] c4, c3;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: index 0 is the DEPTH=4 instance, index 1 the DEPTH=3.
  int m[2][4];
  bit me[2];
  int mc[2];
  int dep[2] = '{4, 3};
  bit started = 1'b0;

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      chk("bus4", bus4, cur.b4);
      chk("bus3", bus3, cur.b3);
      if (cur.chk) begin
        chk("err4", {7'd0, err4}, {7'd0, cur.e4});
        chk("err3", {7'd0, err3}, {7'd0, cur.e3});
        chk("xfer_cnt4", cnt4, cur.c4);
        chk("xfer_cnt3", cnt3, cur.c3);
      end
    end
  end

  // One cycle: apply inputs, record what should be visible this cycle, then
  // advance the model across the coming edge.
  task automatic step(input bit c, input bit re, input logic [1:0] rs,
                      input bit we, input logic [1:0] ws,
                      input bit ie, input logic [1:0] is,
                      input bit ec, input logic [7:0] v);
    int   bv[2];
    exp_t e;
    bit   bad;
    clr = c; rd_en = re; rd_sel = rs; wr_en = we; wr_sel = ws;
    inc_en = ie; inc_sel = is; err_clr = ec; tb_val = v;
    drv4 = !(re && !c && int'(rs) < 4);
    drv3 = !(re && !c && int'(rs) < 3);
    for (int k = 0; k < 2; k++)
      bv[k] = (re && !c && int'(rs) < dep[k]) ? m[k][rs] : int'(v);
    e.chk = started;
    e.b4 = 8'(bv[0]); e.b3 = 8'(bv[1]);
    e.e4 = me[0];     e.e3 = me[1];
    e.c4 = 8'(mc[0]); e.c3 = 8'(mc[1]);
    q.push_back(e);
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        for (int r = 0; r < 4; r++) m[k][r] = 0;
        me[k] = 1'b0;
        mc[k] = 0;
      end else begin
        bad = (re && int'(rs) >= dep[k]) || (we && int'(ws) >= dep[k]) ||
              (INC_ON && ie && int'(is) >= dep[k]);
        if (INC_ON && ie && int'(is) < dep[k]) m[k][is] = (m[k][is] + 1) % 256;
        if (we && int'(ws) < dep[k]) m[k][ws] = bv[k];
        if (bad) me[k] = 1'b1;
        else if (ec) me[k] = 1'b0;
        if (re && we && int'(rs) < dep[k] && int'(ws) < dep[k] && mc[k] < 255) mc[k]++;
      end
    end
    started = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic rd(input logic [1:0] s);
    step(0, 1, s, 0, 0, 0, 0, 0, 8'(($urandom)));
  endtask

  task automatic wr(input logic [1:0] s, input logic [7:0] v);
    step(0, 0, 0, 1, s, 0, 0, 0, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1; rd_en = 0; wr_en = 0; inc_en = 0; err_clr = 0;
    rd_sel = 0; wr_sel = 0; inc_sel = 0; drv4 = 1; drv3 = 1; tb_val = 0;
    @(posedge clk); #1;

    // Reset with a read requested: bus must float; then reset state.
    step(1, 1, 2, 0, 0, 0, 0, 0, 8'h00);
    idle();

    // Externally driven write, then read back every register.
    wr(2, 8'hA5);
    for (int s = 0; s < 4; s++) rd(2'(s));
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'h00);

    // Register-to-register copy over the bus.
    wr(1, 8'h3C);
    step(0, 1, 1, 1, 3, 0, 0, 0, 8'h00);
    rd(3); rd(1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'h00);

    // Increment wrap, then write-beats-increment on the same register.
    wr(0, 8'hFF);
    step(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    rd(0);
    step(0, 0, 0, 1, 0, 1, 0, 0, 8'h10);
    rd(0);
    // Write and increment on different registers in one cycle.
    step(0, 0, 0, 1, 1, 1, 2, 0, 8'h77);
    rd(1); rd(2);

    // Out-of-range write and sticky error handling.
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    wr(3, 8'h5A);
    for (int s = 0; s < 3; s++) rd(2'(s));
    step(0, 0, 0, 1, 3, 0, 0, 1, 8'h66);
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    idle();

    // Increment on reg0 (ignored unless the increment path is built in).
    step(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    rd(0);
    idle();

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 31) == 0), 1'($urandom), 2'($urandom), 1'($urandom),
           2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom_range(0, 3) == 0),
           8'($urandom));

    // Saturating transfer count, then reset in the middle of a transfer.
    for (int i = 0; i < 300; i++)
      step(0, 1, 2'($urandom_range(0, 2)), 1, 2'($urandom_range(0, 2)), 0, 0, 0, 8'h00);
    idle();
    step(1, 1, 0, 1, 1, 1, 1, 1, 8'h00);
    idle();
    for (int s = 0; s < 4; s++) rd(2'(s));
    idle();
    idle();

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_regfile.md
BUS_REGFILE -- requirements
Module: bus_regfile

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bus and register width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of registers (2..16).
REQ-003 Parameter SELW, default 2, SHALL set the select width and SHALL satisfy 2^SELW >= DEPTH.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port clr, input, 1: the reset, synchronous and active-high.
REQ-006 Port bus, inout, WIDTH: the shared data bus.
REQ-007 Port wr_en, input, 1: latch bus into register wr_sel.
REQ-008 Port wr_sel, input, SELW: write target index.
REQ-009 Port rd_en, input, 1: drive register rd_sel onto bus.
REQ-010 Port rd_sel, input, SELW: read source index.
REQ-011 Port inc_en, input, 1: increment register inc_sel.
REQ-012 Port inc_sel, input, SELW: increment target index.
REQ-013 Port err_clr, input, 1: clear the sticky error flag.
REQ-014 Port err, output, 1: sticky flag for a select-range error.
REQ-015 Port xfer_cnt, output, 8: saturating count of bus transfers.

Function
REQ-016 Bus drive is combinational: with rd_en=1, clr=0 and rd_sel<DEPTH, bus SHALL equal reg[rd_sel]; otherwise bus SHALL be high-impedance.
REQ-017 With wr_en=1 and wr_sel<DEPTH, reg[wr_sel] SHALL load the bus value at the clock edge, giving 1-cycle write latency.
REQ-018 rd_en=1 and wr_en=1 in the same cycle SHALL copy reg[rd_sel] into reg[wr_sel] in one cycle; if rd_sel==wr_sel, the register value SHALL be unchanged.
REQ-019 With inc_en=1 and inc_sel<DEPTH, reg[inc_sel] SHALL become reg[inc_sel]+1 modulo 2^WIDTH, so all-ones wraps to 0.
REQ-020 If wr_en and inc_en target the same register, the write SHALL win and the increment SHALL be dropped; when they target different registers, both SHALL take effect in the same cycle.
REQ-021 A write or increment with a select >= DEPTH SHALL modify no register.
REQ-022 err SHALL set at the edge following any cycle with (rd_en & rd_sel>=DEPTH), (wr_en & wr_sel>=DEPTH) or (inc_en & inc_sel>=DEPTH).
REQ-023 err SHALL clear on err_clr; if a set condition and err_clr occur in the same cycle, the set SHALL win.
REQ-024 xfer_cnt SHALL increment by 1 for each cycle with rd_en=1, wr_en=1, and both selects in range.
REQ-025 xfer_cnt SHALL saturate at 255.
REQ-026 A write with rd_en=0 SHALL latch the externally driven bus value.

Reset
REQ-027 While clr=1 at a clock edge, every register, err and xfer_cnt SHALL become 0, and all write, increment and err_clr requests in that cycle SHALL be ignored.
REQ-028 While clr=1, bus SHALL be high-impedance regardless of rd_en, including when clr is asserted in the middle of a transfer.
REQ-029 The first operation SHALL be accepted in the first cycle after clr deasserts.

Configuration
REQ-030 With macro BUS_REGFILE_INC_EN defined, increment behaviour SHALL be as in REQ-019 and REQ-020, with inc_sel range errors per REQ-022.
REQ-031 Without BUS_REGFILE_INC_EN, the inc_en and inc_sel ports SHALL remain present but SHALL be ignored and SHALL never set err.

Verification
REQ-032 The bench SHALL cover: clr; drive bus 8'hA5 with wr_en=1, wr_sel=2; then rd_en=1, rd_sel=2 -> bus=8'hA5 and other registers remain 0.
REQ-033 The bench SHALL cover: reg1=8'h3C, then rd_en=1, rd_sel=1, wr_en=1, wr_sel=3 -> reg3=8'h3C after 1 cycle and xfer_cnt=1.
REQ-034 The bench SHALL cover: reg0=8'hFF, then inc_en=1, inc_sel=0 -> reg0=8'h00; in a further cycle with wr_en and inc_en both selecting reg0 and bus=8'h10, reg0=8'h10.
REQ-035 The bench SHALL cover: DEPTH=3, wr_en=1, wr_sel=3 -> no register changes and err=1; then err_clr together with another bad select -> err stays 1; then err_clr alone -> err=0.
REQ-036 The bench SHALL cover: 300 consecutive valid transfers -> xfer_cnt=255; then clr asserted with rd_en=1 -> bus high-impedance and all state 0 after the edge.
REQ-037 The bench SHALL cover: with BUS_REGFILE_INC_EN undefined, inc_en=1 with inc_sel=0 -> reg0 unchanged and err=0.
